// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SLL/SRL/ROL/SRA by a run-time amount, up to STEP
// bit positions per cycle, driven through a start/busy/done handshake.
module seq_shifter #(
    parameter int N    = 32,
    parameter int SHW  = 5,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   a,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_SRA = 2'b11;

    // STEP may equal N, so it needs one more bit than the shift amount.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    state_t           state_r;
    state_t           state_nx_s;
    logic [N-1:0]     data_r;
    logic [SHW-1:0]   rem_r;
    logic [1:0]       mode_r;
    logic [SHW:0]     k_s;
    logic [SHW-1:0]   rem_nx_s;
    logic [N-1:0]     shifted_s;
    logic [2*N-1:0]   rot_s;

    // Per-step shift: k = min(STEP, rem) positions in the latched mode.
    always_comb begin
        k_s       = {(SHW+1){1'b0}};
        rem_nx_s  = rem_r;
        shifted_s = data_r;
        rot_s     = {data_r, data_r} << k_s;
        if ({1'b0, rem_r} < STEP_W) begin
            k_s = {1'b0, rem_r};
        end else begin
            k_s = STEP_W;
        end
        rot_s    = {data_r, data_r} << k_s;
        rem_nx_s = rem_r - k_s[SHW-1:0];
        case (mode_r)
            MODE_SLL: shifted_s = data_r << k_s;
            MODE_SRL: shifted_s = data_r >> k_s;
            MODE_ROL: shifted_s = rot_s[2*N-1:N];
            MODE_SRA: shifted_s = $signed(data_r) >>> k_s;
            default:  shifted_s = data_r;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (shamt != {SHW{1'b0}}) begin
                        state_nx_s = SHIFT;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_nx_s == {SHW{1'b0}}) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Datapath registers: operand capture on accepted start, one step per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {N{1'b0}};
            rem_r  <= {SHW{1'b0}};
            mode_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        data_r <= a;
                        rem_r  <= shamt;
                        mode_r <= mode;
                    end
                end
                SHIFT: begin
                    data_r <= shifted_s;
                    rem_r  <= rem_nx_s;
                end
                default: begin
                    data_r <= data_r;
                    rem_r  <= rem_r;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            SHIFT: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign result = data_r;

endmodule
